// File: rtl/intpoln_controlpath.sv
// intpoln_controlpath: runtime-factor sequencer for the quadratic FIFO-to-FIFO interpolator; INTPOLN_STALL_CNT_EN adds stall_cnt
module intpoln_controlpath #(
    parameter int LOG2_D_MAX = 3,
    parameter int LEN_W      = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic                              mode,
    input  logic                              bypass,
    input  logic [$clog2(LOG2_D_MAX+1)-1:0]   dlog2,
    input  logic [LEN_W-1:0]                  ilen,
    input  logic                              empty_i,
    input  logic                              afull_i,
    output logic                              rd_en,
    output logic                              ld_shift,
    output logic [LOG2_D_MAX-1:0]             xi,
    output logic                              en_sum,
    output logic                              wr_en,
    output logic                              wr_bypass,
    output logic                              clear,
    output logic                              busy,
    output logic                              stop_empty,
    output logic                              stop_afull,
`ifdef INTPOLN_STALL_CNT_EN
    output logic [15:0]                       stall_cnt,
`endif
    output logic                              done
);
    localparam int DW = $clog2(LOG2_D_MAX + 1);

    typedef enum logic [2:0] {IDLE, PRIME, CALC, REFILL, BYPASS, DONE} state_t;

    state_t                state_q, state_d;
    logic                  start_q, start_d;
    logic                  mode_q, mode_d;
    logic                  byp_q, byp_d;
    logic [LEN_W-1:0]      ilen_q, ilen_d;
    logic [DW-1:0]         dl_q, dl_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LOG2_D_MAX-1:0] xi_q, xi_d;
    logic                  ld_shift_q, ld_shift_d;
    logic                  wr_bypass_q, wr_bypass_d;
    logic                  clear_q, clear_d;
    logic [LOG2_D_MAX-1:0] xmask;
    logic [LEN_W-1:0]      cnt_inc;
    logic                  more;

    // xmask = D-1 for the latched factor; xi wraps when it reaches it
    assign xmask   = ~({LOG2_D_MAX{1'b1}} << dl_q);
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign more    = cnt_q != ilen_q;

    always_comb begin
        state_d    = state_q;
        start_d    = start;
        mode_d     = mode_q;
        byp_d      = byp_q;
        ilen_d     = ilen_q;
        dl_d       = dl_q;
        cnt_d      = cnt_q;
        xi_d       = xi_q;
        clear_d    = 1'b0;
        rd_en      = 1'b0;
        en_sum     = 1'b0;
        wr_en      = 1'b0;
        stop_empty = 1'b0;
        stop_afull = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    mode_d  = mode;
                    byp_d   = bypass;
                    ilen_d  = ilen;
                    dl_d    = (dlog2 > DW'(LOG2_D_MAX)) ? DW'(LOG2_D_MAX) : dlog2;
                    cnt_d   = '0;
                    xi_d    = '0;
                    clear_d = 1'b1;
                    state_d = bypass ? ((ilen == '0) ? DONE : BYPASS)
                            : (ilen < LEN_W'(3) && !mode) ? DONE : PRIME;
                end
            end
            PRIME: begin
                rd_en      = !empty_i;
                stop_empty = empty_i;
                if (rd_en) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LEN_W'(2)) begin
                        state_d = CALC;
                        xi_d    = '0;
                    end
                end
            end
            CALC: begin
                stop_afull = afull_i;
                if (!afull_i) begin
                    wr_en  = 1'b1;
                    en_sum = 1'b1;
                    xi_d   = (xi_q == xmask) ? '0 : xi_q + 1'b1;
                    if (xi_q == xmask)
                        state_d = (mode_q ? !start : cnt_q == ilen_q) ? DONE : REFILL;
                end
            end
            REFILL: begin
                stop_empty = empty_i;
                if (!empty_i) begin
                    rd_en   = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = CALC;
                end
            end
            BYPASS: begin
                rd_en      = more && !empty_i && !afull_i;
                stop_empty = more && empty_i;
                stop_afull = more && !empty_i && afull_i;
                if (rd_en)
                    cnt_d = cnt_inc;
                // the final read's wr_bypass is out in this same cycle
                if (!more)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ld_shift_d  = rd_en && !byp_q;
        wr_bypass_d = rd_en && byp_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            mode_q      <= 1'b0;
            byp_q       <= 1'b0;
            ilen_q      <= '0;
            dl_q        <= '0;
            cnt_q       <= '0;
            xi_q        <= '0;
            ld_shift_q  <= 1'b0;
            wr_bypass_q <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            mode_q      <= mode_d;
            byp_q       <= byp_d;
            ilen_q      <= ilen_d;
            dl_q        <= dl_d;
            cnt_q       <= cnt_d;
            xi_q        <= xi_d;
            ld_shift_q  <= ld_shift_d;
            wr_bypass_q <= wr_bypass_d;
            clear_q     <= clear_d;
        end
    end

`ifdef INTPOLN_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = clear_d ? '0
                : ((stop_empty || stop_afull) && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

    assign ld_shift  = ld_shift_q;
    assign wr_bypass = wr_bypass_q;
    assign clear     = clear_q;
    assign xi        = xi_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_intpoln_controlpath.sv
// tb_intpoln_controlpath: directed runs of the interpolator control path with hand-computed event counts
module tb_intpoln_controlpath;
    logic       clk = 1'b0;
    logic       rstn, start, mode, bypass, empty_i, afull_i;
    logic [1:0] dlog2;
    logic [7:0] ilen;
    logic       rd_en, ld_shift, en_sum, wr_en, wr_bypass, clear, busy;
    logic       stop_empty, stop_afull, done;
    logic [2:0] xi;
`ifdef INTPOLN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0, errors = 0;
    int n_rd, n_wr, n_byp, n_done, n_sa, n_se, n_clear;
    int xi_exp, dmask;
    logic byp_t = 1'b0, prev_rd = 1'b0;

    intpoln_controlpath #(.LOG2_D_MAX(3), .LEN_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .bypass(bypass),
        .dlog2(dlog2), .ilen(ilen), .empty_i(empty_i), .afull_i(afull_i),
        .rd_en(rd_en), .ld_shift(ld_shift), .xi(xi), .en_sum(en_sum),
        .wr_en(wr_en), .wr_bypass(wr_bypass), .clear(clear), .busy(busy),
        .stop_empty(stop_empty), .stop_afull(stop_afull),
`ifdef INTPOLN_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // per-cycle monitor: strobe timing, xi sequence and event counts
    always @(negedge clk) begin
        if (!rstn) begin
            prev_rd = 1'b0;
        end else begin
            chk("cyc", int'({wr_bypass, ld_shift, en_sum, stop_empty & stop_afull}),
                int'({byp_t & prev_rd, !byp_t & prev_rd, wr_en, 1'b0}));
            if (wr_en) begin
                chk("xi", int'(xi), xi_exp);
                xi_exp = (xi_exp + 1) & dmask;
            end
            n_rd    += int'(rd_en);
            n_wr    += int'(wr_en);
            n_byp   += int'(wr_bypass);
            n_done  += int'(done);
            n_sa    += int'(stop_afull);
            n_se    += int'(stop_empty);
            n_clear += int'(clear);
            prev_rd = rd_en;
        end
    end

    task automatic zero_cnt();
        n_rd = 0; n_wr = 0; n_byp = 0; n_done = 0; n_sa = 0; n_se = 0; n_clear = 0;
    endtask

    task automatic run(input string tag, input logic m, input logic b, input logic [1:0] dl,
                       input logic [7:0] len, input int a0, input int al, input int e0,
                       input int el, input int sw, input int er, input int ew, input int eb,
                       input int esa, input int ese);
        logic hit;
        @(posedge clk); #1;
        zero_cnt();
        mode = m; bypass = b; dlog2 = dl; ilen = len; byp_t = b;
        xi_exp = 0; dmask = (1 << dl) - 1;
        afull_i = 1'b0; empty_i = 1'b0; start = 1'b1;
        hit = 1'b0;
        for (int k = 1; k < 400 && !hit; k++) begin
            @(posedge clk); #1;
            afull_i = (k >= a0 && k < a0 + al);
            empty_i = (k >= e0 && k < e0 + el);
            start   = (sw == 0) ? (k < 2) : (n_wr < sw);
            hit     = n_done > 0;
        end
        start = 1'b0; afull_i = 1'b0; empty_i = 1'b0;
        chk({tag, "_finished"}, int'(hit), 1);
        chk({tag, "_busy_after"}, int'({busy, done}), 0);
        chk({tag, "_done"}, n_done, 1);
        chk({tag, "_clear"}, n_clear, 1);
        chk({tag, "_rd"}, n_rd, er);
        chk({tag, "_wr"}, n_wr, ew);
        chk({tag, "_wrbyp"}, n_byp, eb);
        chk({tag, "_stop_afull"}, n_sa, esa);
        chk({tag, "_stop_empty"}, n_se, ese);
`ifdef INTPOLN_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, int'(stall_cnt), esa + ese);
`endif
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; mode = 1'b0; bypass = 1'b0;
        dlog2 = 2'd0; ilen = 8'd0; empty_i = 1'b0; afull_i = 1'b0;
        zero_cnt();
        xi_exp = 0; dmask = 0;
        @(posedge clk); #1;
        chk("reset_outs", int'({rd_en, ld_shift, xi, en_sum, wr_en, wr_bypass, clear, busy,
                                stop_empty, stop_afull, done}), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        //   tag       m     b     dl    len  a0 al e0 el sw  rd  wr  byp sa se
        run("basic",  1'b0, 1'b0, 2'd2, 8'd5, 0, 0, 0, 0, 0,  5, 12, 0,  0, 0);
        run("afull",  1'b0, 1'b0, 2'd2, 8'd5, 5, 5, 0, 0, 0,  5, 12, 0,  5, 0);
        run("empty",  1'b0, 1'b0, 2'd2, 8'd5, 0, 0, 8, 3, 0,  5, 12, 0,  0, 3);
        run("bypass", 1'b0, 1'b1, 2'd2, 8'd4, 0, 0, 0, 0, 0,  4,  0, 4,  0, 0);
        run("short",  1'b0, 1'b0, 2'd2, 8'd2, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0);
        run("dmax",   1'b0, 1'b0, 2'd3, 8'd4, 0, 0, 0, 0, 0,  4, 16, 0,  0, 0);
        run("stream", 1'b1, 1'b0, 2'd0, 8'd0, 0, 0, 0, 0, 10, 13, 11, 0, 0, 0);
        // reset in the middle of CALC: everything returns to zero, no done pulse
        @(posedge clk); #1;
        zero_cnt();
        mode = 1'b1; bypass = 1'b0; dlog2 = 2'd2; byp_t = 1'b0;
        xi_exp = 0; dmask = 3; start = 1'b1;
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_in_calc", int'(wr_en), 1);
        rstn = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("abort_outs", int'({rd_en, ld_shift, xi, en_sum, wr_en, wr_bypass, clear, busy,
                                stop_empty, stop_afull, done}), 0);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", int'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
